// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Iterative RV32M multiply/divide controller for the execute stage.
// Multiplies use a shift-add loop and divides a restoring loop, one radix-2
// step per cycle over XLEN cycles. Divide-by-zero and signed overflow are
// resolved at start and skip the loop.
//
// Optional feature: define MULDIV_FAST_MUL_EN to compute all four multiplies
// with one combinational XLEN x XLEN multiplier registered at start
// (IDLE -> DONE). Divides stay iterative in both builds.
//
// Ports
//   clk        core clock, rising edge
//   rst        synchronous active-high reset
//   start      EX holds a valid M-type op; sampled only in IDLE
//   flush      EX-stage flush; aborts any operation, beats start
//   func3      000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
//   op1, op2   rs1 / rs2 values
//   rd         destination register
//   busy       operation in flight (CALC)
//   ready      result valid this cycle (DONE, one cycle)
//   result     final result, held outside DONE
//   wr         register-file write strobe (ready && dest != 0)
//   dest       latched rd
//   state_dbg  FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: start is a level request observed only in IDLE; the consumer
// takes result/dest when ready is high, there is no back-pressure.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            ready,
  output logic [XLEN-1:0] result,
  output logic            wr,
  output logic [4:0]      dest,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          func3_q, func3_d;
  logic [4:0]          dest_q, dest_d;
  logic                neg_q, neg_d;
  // Multiply: {partial product high, multiplier shifting out}.
  // Divide: low half is the dividend shifting out / quotient shifting in.
  logic [2*XLEN-1:0]   acc_q, acc_d;
  // Multiplicand or divisor magnitude.
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Operand decode at start
  logic            sgn1, sgn2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div0, ovf;

  // Datapath step results
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem_next;
  logic [XLEN-1:0]   div_quo_next;
  logic [XLEN-1:0]   div_val;
  logic [XLEN-1:0]   div_res;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]   fast_res;

  always_comb begin
    fast_a    = {{XLEN{op1[XLEN-1] & (func3 == 3'b001 || func3 == 3'b010)}}, op1};
    fast_b    = {{XLEN{op2[XLEN-1] & (func3 == 3'b001)}}, op2};
    fast_prod = fast_a * fast_b;
    fast_res  = (func3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    case (func3)
      3'b001, 3'b100, 3'b110: begin
        sgn1 = op1[XLEN-1];
        sgn2 = op2[XLEN-1];
      end
      3'b010:  sgn1 = op1[XLEN-1];
      default: ;
    endcase
    mag1 = sgn1 ? -op1 : op1;
    mag2 = sgn2 ? -op2 : op2;
    div0 = func3[2] && (op2 == '0);
    ovf  = func3[2] && !func3[0] && (op1 == MIN_NEG) && (op2 == '1);
  end

  // One shift-add step: conditionally add the multiplicand into the high
  // half (keeping the carry), then shift the whole accumulator right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    prod_fin = neg_q ? -mul_next : mul_next;
    mul_res  = (func3_q[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
  end

  // One restoring step on an XLEN+1-bit partial remainder. The shifted
  // remainder never exceeds 2*divisor-1, so the difference always fits in
  // XLEN+1 bits and its top bit is a valid sign.
  always_comb begin
    div_shift    = {rem_q, acc_q[XLEN-1]};
    div_diff     = div_shift - {1'b0, mcand_q};
    div_ge       = !div_diff[XLEN];
    div_rem_next = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    div_quo_next = {acc_q[XLEN-2:0], div_ge};
    div_val      = func3_q[1] ? div_rem_next : div_quo_next;
    div_res      = neg_q ? -div_val : div_val;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    func3_d  = func3_q;
    dest_d   = dest_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    rem_d    = rem_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          func3_d = func3;
          dest_d  = rd;
          cnt_d   = '0;
          neg_d   = 1'b0;
          if (div0) begin
            result_d = func3[1] ? op1 : '1;
            state_d  = S_DONE;
          end else if (ovf) begin
            result_d = func3[1] ? '0 : MIN_NEG;
            state_d  = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!func3[2]) begin
            result_d = fast_res;
            state_d  = S_DONE;
`endif
          end else begin
            // REM takes the dividend's sign; MUL*/DIV the XOR of both.
            neg_d   = (func3[2] && func3[1]) ? sgn1 : (sgn1 ^ sgn2);
            acc_d   = {{XLEN{1'b0}}, mag1};
            mcand_d = mag2;
            rem_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (func3_q[2]) begin
          acc_d = {acc_q[2*XLEN-1:XLEN], div_quo_next};
          rem_d = div_rem_next;
        end else begin
          acc_d = mul_next;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          result_d = func3_q[2] ? div_res : mul_res;
          state_d  = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      func3_d = '0;
      dest_d  = '0;
      neg_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      func3_q  <= '0;
      dest_q   <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      func3_q  <= func3_d;
      dest_q   <= dest_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign busy      = (state_q == S_CALC);
  assign ready     = (state_q == S_DONE);
  assign wr        = ready && (dest_q != 5'd0);
  assign result    = result_q;
  assign dest      = dest_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: directed RV32M cases, abort/reset/collision
// scenarios and randomized operations against a plain-arithmetic model.
module tb_muldiv_sequencer;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            flush;
  logic [2:0]      func3;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [4:0]      rd;
  logic            busy;
  logic            ready;
  logic [XLEN-1:0] result;
  logic            wr;
  logic [4:0]      dest;
  logic [1:0]      state_dbg;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flush     (flush),
    .func3     (func3),
    .op1       (op1),
    .op2       (op2),
    .rd        (rd),
    .busy      (busy),
    .ready     (ready),
    .result    (result),
    .wr        (wr),
    .dest      (dest),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  logic [XLEN-1:0] exp_q[$];
  logic [4:0]      exp_dest_q[$];
  logic            exp_wr_q[$];
  int              exp_cyc_q[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model straight from the RV32M definitions.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, zb, t;
    logic [63:0] p;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    zb = longint'({32'b0, b});
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'd0: begin t = sa * sb; p = t; return p[31:0]; end
      3'd1: begin t = sa * sb; p = t; return p[63:32]; end
      3'd2: begin t = sa * zb; p = t; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        t = sa / sb; p = t; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        t = sa % sb; p = t; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return XLEN + 1;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_ready_exclusive", 64'(busy & ready), 64'd0);
      if (ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready got result %0h expected no ready (cycle %0d)", result, cyc);
        end else begin
          check("result", 64'(result), 64'(exp_q.pop_front()));
          check("dest", 64'(dest), 64'(exp_dest_q.pop_front()));
          check("wr", 64'(wr), 64'(exp_wr_q.pop_front()));
          check("ready_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
        end
      end else if (exp_cyc_q.size() > 0 && cyc >= exp_cyc_q[0]) begin
        checks++;
        errors++;
        $display("FAIL missing_ready got no ready expected ready at cycle %0d (cycle %0d)", exp_cyc_q[0], cyc);
        void'(exp_q.pop_front());
        void'(exp_dest_q.pop_front());
        void'(exp_wr_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called 1ns after a rising edge; the op is sampled on the next edge.
  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input bit push, output int lat);
    func3 = f;
    op1   = a;
    op2   = b;
    rd    = r;
    start = 1'b1;
    lat   = model_latency(f, a, b);
    if (push) begin
      exp_q.push_back(ref_model(f, a, b));
      exp_dest_q.push_back(r);
      exp_wr_q.push_back(r != 5'd0);
      exp_cyc_q.push_back(cyc + lat);
    end
  endtask

  // Issues one op and returns so that the next op lands on the earliest
  // accepted cycle (T + latency + 1).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    int lat;
    @(posedge clk); #1;
    launch(f, a, b, r, 1'b1, lat);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(lat != 1));
    repeat (lat - 1) @(posedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int k;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    func3 = '0; op1 = '0; op2 = '0; rd = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_wr", 64'(wr), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_dest", 64'(dest), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    rst = 1'b0;

    // MUL 7 * -6 with per-cycle busy window
    @(posedge clk); #1;
    launch(3'd0, 32'd7, 32'hFFFF_FFFA, 5'd5, 1'b1, lat);
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
      if (i < lat) check("mul_busy_window", 64'(busy), 64'd1);
      else check("mul_busy_in_done", 64'(busy), 64'd0);
    end

    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    run_op(3'd2, 32'hFFFF_FFFE, 32'h8000_0001, 5'd3);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
    run_op(3'd7, 32'd100, 32'd7, 5'd7);
    run_op(3'd5, 32'd12345, 32'd0, 5'd8);
    run_op(3'd6, 32'd13, 32'd0, 5'd9);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op(3'd0, 32'd3, 32'd4, 5'd0);

    // Flush at T+10 of a DIV, new op launched at T+11
    @(posedge clk); #1;
    launch(3'd4, 32'hFFFF_FFF9, 32'd3, 5'd7, 1'b0, lat);
    k = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_state_idle", 64'(state_dbg), 64'd0);
    check("flush_cycle", 64'(cyc - k), 64'd11);
    launch(3'd4, 32'd100, 32'd7, 5'd9, 1'b1, lat);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (lat - 1) @(posedge clk);

    // Reset pulse at T+20 of a MUL
    @(posedge clk); #1;
    launch(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 1'b0, lat);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(ready), 64'd0);
    check("midrst_wr", 64'(wr), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_dest", 64'(dest), 64'd0);

    // start held through CALC and DONE: exactly one completion
    @(posedge clk); #1;
    launch(3'd5, 32'd1000, 32'd9, 5'd12, 1'b1, lat);
    repeat (lat + 1) @(posedge clk);
    #1;
    start = 1'b0;
    check("held_no_relaunch", 64'(busy), 64'd0);

    // flush and start together: no operation begins
    @(posedge clk); #1;
    launch(3'd4, 32'd50, 32'd5, 5'd4, 1'b0, lat);
    flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);
    check("flush_start_state", 64'(state_dbg), 64'd0);
    repeat (40) @(posedge clk);

    // randomized operations
    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)));
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog got timeout expected completion (cycle %0d)", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative RV32M multiply/divide controller for the execute stage. It accepts one M-type operation at a time from ID/EX, runs a shift-add multiply or restoring divide over XLEN cycles, and returns the result with a one-cycle write strobe. It drives `busy`/`ready` into the hazard unit, which stalls the pipeline on `busy || ready`. It feeds the result into the EX/MEM result mux.

## Interface
- `XLEN`, default 32: operand/result width. Iteration count equals `XLEN`.
- `clk` in 1: core clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: EX holds a valid M-type instruction. Sampled only in IDLE.
- `flush` in 1: EX-stage flush (taken jump/branch); aborts any operation.
- `func3` in 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op1` in XLEN: rs1 value, already forwarded.
- `op2` in XLEN: rs2 value, already forwarded.
- `rd` in 5: destination register.
- `busy` out 1: operation in flight (CALC state).
- `ready` out 1: result valid this cycle (DONE state, exactly one cycle).
- `result` out XLEN: final result; holds its last value outside DONE.
- `wr` out 1: register-file write strobe; equals `ready && dest != 0`.
- `dest` out 5: latched `rd` of the operation in flight.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On `start && !flush`, latch `func3`, `rd`, operand magnitudes and result sign, and clear the counter.
  - Go to CALC, or straight to DONE for a special case.
- CALC:
  - One radix-2 step per cycle. The counter runs 0..XLEN-1.
  - On the step with counter = XLEN-1, go to DONE.
- DONE:
  - Apply the sign correction (two's-complement negate if the latched sign is set).
  - Select the low or high word (MUL low; MULH/MULHSU/MULHU high).
  - Assert `ready`, then return to IDLE.
- Signedness:
  - MULH: both operands signed. MULHSU: op1 signed, op2 unsigned. MULHU, DIVU, REMU: unsigned.
  - DIV: quotient sign = sign(op1) XOR sign(op2). REM: remainder sign = sign(op1).
- Special cases, decided at start (IDLE → DONE, no CALC):
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = op1.
  - Signed overflow (op1 = 0x80000000, op2 = 0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
- Product accumulator is 2·XLEN bits. Divider keeps an XLEN+1-bit partial remainder. All arithmetic is modulo its width.
- `start` in CALC or DONE is ignored; the hazard stall guarantees EX holds the instruction.
- `flush` in any state: next state IDLE, internal sign/latch state cleared, no `ready`/`wr` for the aborted operation. If `flush` and `start` occur in the same cycle, flush wins and `start` is dropped.
- Reset values: state IDLE, `busy` 0, `ready` 0, `wr` 0, `result` 0, `dest` 0, counter 0.
- Reset mid-operation: abort to IDLE; no `ready` is produced.

## Timing
- `start` sampled in cycle T:
  - `busy` = 1 in cycles T+1..T+XLEN.
  - `ready`/`wr` = 1 in cycle T+XLEN+1.
  - Earliest next `start` accepted at T+XLEN+2.
- Special case: `ready` in cycle T+1, `busy` never asserted.
- `result`, `dest` and `wr` are registered outputs, stable for the whole DONE cycle.
- `busy` and `ready` are never high in the same cycle.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL/MULH/MULHSU/MULHU compute with a single combinational XLEN×XLEN multiplier registered at start. The FSM goes IDLE → DONE, so `ready` is in T+1 and `busy` is never high for multiplies.
  - Divides are unchanged (iterative).
- `MULDIV_FAST_MUL_EN` not defined: all eight operations use the iterative path with XLEN+1 latency.

## Test plan
- MUL, op1 = 7, op2 = 0xFFFFFFFA (−6), rd = 5, start in T:
  - `busy` high T+1..T+32.
  - `ready`, `wr` in T+33 with `result` = 0xFFFFFFD6 and `dest` = 5.
- MULH, op1 = op2 = 0x80000000 → `result` = 0x40000000. MULHU, 0xFFFFFFFF × 0xFFFFFFFF → `result` = 0xFFFFFFFE.
- DIV, op1 = −7, op2 = 2 → `result` = 0xFFFFFFFD (−3). REM with the same operands → `result` = 0xFFFFFFFF (−1). REMU, 100 ÷ 7 → `result` = 2.
- Special cases (each must return `ready` in T+1):
  - DIVU x ÷ 0 → `result` = 0xFFFFFFFF.
  - REM 13 ÷ 0 → `result` = 13.
  - DIV 0x80000000 ÷ −1 → `result` = 0x80000000.
- Abort and write suppression:
  - Flush asserted at T+10 of a DIV → IDLE at T+11, no `ready` ever for that operation.
  - A new `start` at T+11 completes normally at T+44.
  - `rd` = 0 → `ready` = 1, `wr` = 0.
- Reset and start collisions:
  - `rst` pulse at T+20 of a MUL → all outputs 0 next cycle.
  - `start` held high through CALC → no re-launch.
  - `flush` and `start` in the same cycle → no operation begins.
